seg7_scan_ctrl: RTL



---
 rtl/seg7_scan_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner: per-frame shadowed value, blank window per slot,
// decimal points, leading-zero suppression and enable. Optional BLINK_EN adds per-digit blink.
module seg7_scan_ctrl #(
  parameter int DIGITS       = 6,
  parameter int CLK_HZ       = 50_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [4*DIGITS-1:0]   num,
  input  logic [DIGITS-1:0]     dp,
`ifdef BLINK_EN
  input  logic [DIGITS-1:0]     blink,
`endif
  input  logic                  lz_blank,
  input  logic                  enable,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_done
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int PRE_W = $clog2(DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIV - 1);
  localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [6:0]       SEG_OFF   = 7'b1111111;

  logic [PRE_W-1:0]    prescaler;
  logic [IDX_W-1:0]    index;
  logic                load;
  logic [4*DIGITS-1:0] shadow_num;
  logic [DIGITS-1:0]   shadow_dp;

  logic tick;
  logic wrap;
  logic shadow_en;
  logic dark;

  assign tick      = (prescaler == PRE_LAST);
  assign wrap      = tick && (index == IDX_LAST);
  assign shadow_en = load || wrap;
  assign dark      = !enable || (prescaler < PRE_BLANK);

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Refresh prescaler and digit index; the index only moves on the slot tick.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!RST_N) begin
      prescaler <= '0;
      index     <= '0;
      load      <= 1'b1;
    end else begin
      load <= 1'b0;
      if (tick) begin
        prescaler <= '0;
        index     <= (index == IDX_LAST) ? '0 : index + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: the shadow registers are reset because the first frame's digits are decoded from them.
    if (!RST_N) begin
      shadow_num <= '0;
      shadow_dp  <= '0;
    end else if (shadow_en) begin
      shadow_num <= num;
      shadow_dp  <= dp;
    end
  end

`ifdef BLINK_EN
  logic [DIGITS-1:0] shadow_blink;
  logic [5:0]        frame_cnt;
  logic              phase;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      shadow_blink <= '0;
      frame_cnt    <= '0;
      phase        <= 1'b0;
    end else begin
      if (shadow_en) shadow_blink <= blink;
      if (wrap) begin
        frame_cnt <= frame_cnt + 1'b1;
        if (frame_cnt == 6'd63) phase <= ~phase;
      end
    end
  end
`endif

  // zero_from[k]: shadow nibbles and dp bits k..DIGITS-1 are all zero.
  logic [DIGITS:0]   zero_from;
  logic [DIGITS-1:0] suppress;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    zero_from         = '0;
    suppress          = '0;
    zero_from[DIGITS] = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_from[k] = zero_from[k+1] && (shadow_num[4*k +: 4] == 4'h0) && !shadow_dp[k];
    end
    for (int k = 1; k < DIGITS; k++) begin
      suppress[k] = lz_blank && zero_from[k];
    end
  end

  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_hide;
  logic [DIGITS-1:0] cur_sel;

  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_hide = 1'b0;
    cur_sel  = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (index == IDX_W'(k)) begin
        cur_nib               = shadow_num[4*k +: 4];
        cur_dp                = shadow_dp[k];
`ifdef BLINK_EN
        cur_hide              = suppress[k] || (phase && shadow_blink[k]);
`else
        cur_hide              = suppress[k];
`endif
        cur_sel[DIGITS-1-k]   = 1'b0;
      end
    end
  end

  // Hidden digits keep their select asserted so every slot has the same lit time.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sel        <= '1;
      seg        <= SEG_OFF;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (dark) begin
        sel  <= '1;
        seg  <= SEG_OFF;
        dp_n <= 1'b1;
      end else begin
        sel <= cur_sel;
        if (cur_hide) begin
          seg  <= SEG_OFF;
          dp_n <= 1'b1;
        end else begin
          seg  <= seg_decode(cur_nib);
          dp_n <= ~cur_dp;
        end
      end
    end
  end

endmodule
